// File: rtl/multi_timer.sv
// Multi-channel interval timer: NUM_CH independent prescaled down-counters behind an
// Avalon-MM slave, with per-channel timeout pulses, snapshot registers and a combined IRQ.
module multi_timer #(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned CNT_W        = 32,
   parameter logic [31:0] RESET_PERIOD = 32'h98967
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [4:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [NUM_CH-1:0] irq_vec,
   output logic [NUM_CH-1:0] timeout_pulse
);
   localparam int unsigned      PRESC_W     = 8;
   localparam logic [CNT_W-1:0] RST_PERIOD  = RESET_PERIOD[CNT_W-1:0];
   localparam logic [1:0]       REG_STATUS  = 2'd0;
   localparam logic [1:0]       REG_CONTROL = 2'd1;
   localparam logic [1:0]       REG_PERIOD  = 2'd2;

   logic [CNT_W-1:0]   count_q  [NUM_CH];
   logic [CNT_W-1:0]   count_d  [NUM_CH];
   logic [CNT_W-1:0]   period_q [NUM_CH];
   logic [CNT_W-1:0]   period_d [NUM_CH];
   logic [CNT_W-1:0]   snap_q   [NUM_CH];
   logic [CNT_W-1:0]   snap_d   [NUM_CH];
   logic [PRESC_W-1:0] presc_q  [NUM_CH];
   logic [PRESC_W-1:0] presc_d  [NUM_CH];
   logic [PRESC_W-1:0] div_q    [NUM_CH];
   logic [PRESC_W-1:0] div_d    [NUM_CH];
   logic [NUM_CH-1:0]  to_q, to_d, run_q, run_d, ito_q, ito_d, cont_q, cont_d;
   logic [NUM_CH-1:0]  load_q, load_d, irq_vec_q, irq_vec_d, pulse_q, pulse_d;
   logic               irq_q, irq_d;
   logic [31:0]        readdata_q, readdata_d;

   logic              wr_en;
   logic [2:0]        ch_sel;
   logic [1:0]        reg_sel;
   logic [NUM_CH-1:0] wr_stat, wr_ctrl, wr_per, wr_snap, start, stop, tick, to_evt;
   logic              unused_wd;

   assign unused_wd = ^writedata;

   // Bus decode plus per-channel tick and timeout detection
   always_comb begin
      wr_en   = chipselect & ~write_n;
      ch_sel  = address[4:2];
      reg_sel = address[1:0];
      wr_stat = '0;
      wr_ctrl = '0;
      wr_per  = '0;
      wr_snap = '0;
      start   = '0;
      stop    = '0;
      tick    = '0;
      to_evt  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_en && ch_sel == 3'(i)) begin
            wr_stat[i] = (reg_sel == REG_STATUS);
            wr_ctrl[i] = (reg_sel == REG_CONTROL);
            wr_per[i]  = (reg_sel == REG_PERIOD);
            wr_snap[i] = (reg_sel == 2'd3);
         end
         start[i]  = wr_ctrl[i] & writedata[2];
         stop[i]   = wr_ctrl[i] & writedata[3];
         tick[i]   = run_q[i] && (div_q[i] == presc_q[i]);
         to_evt[i] = tick[i] && (count_q[i] == '0);
      end
   end

   // Next-state for every channel; a timeout set always beats a W1C clear
   always_comb begin
      count_d  = count_q;
      period_d = period_q;
      snap_d   = snap_q;
      presc_d  = presc_q;
      div_d    = div_q;
      to_d     = to_q;
      run_d    = run_q;
      ito_d    = ito_q;
      cont_d   = cont_q;
      load_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (load_q[i] || to_evt[i]) begin
            count_d[i] = period_q[i];
         end else if (tick[i]) begin
            count_d[i] = count_q[i] - CNT_W'(1);
         end

         if (!run_q[i] || tick[i] || start[i] || wr_per[i]) begin
            div_d[i] = '0;
         end else begin
            div_d[i] = div_q[i] + 8'd1;
         end

         if (to_evt[i] && !cont_q[i]) run_d[i] = 1'b0;
         if (wr_per[i] || stop[i])    run_d[i] = 1'b0;
         if (start[i])                run_d[i] = 1'b1;

         if (wr_stat[i] && writedata[0]) to_d[i] = 1'b0;
         if (to_evt[i])                  to_d[i] = 1'b1;

         if (wr_per[i]) begin
            period_d[i] = writedata[CNT_W-1:0];
            load_d[i]   = 1'b1;
         end
         if (wr_snap[i]) snap_d[i] = count_q[i];
         if (wr_ctrl[i]) begin
            ito_d[i]   = writedata[0];
            cont_d[i]  = writedata[1];
            presc_d[i] = writedata[15:8];
         end
      end
      irq_vec_d = to_d & ito_d;
      irq_d     = |irq_vec_d;
      pulse_d   = to_evt;
   end

   // Read mux: registers as they stand before the sampling edge
   always_comb begin
      readdata_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 3'(i)) begin
            case (reg_sel)
               REG_STATUS:  readdata_d = {30'd0, run_q[i], to_q[i]};
               REG_CONTROL: readdata_d = {16'd0, presc_q[i], 6'd0, cont_q[i], ito_q[i]};
               REG_PERIOD:  readdata_d = 32'(period_q[i]);
               default:     readdata_d = 32'(snap_q[i]);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            count_q[i]  <= RST_PERIOD;
            period_q[i] <= RST_PERIOD;
            snap_q[i]   <= '0;
            presc_q[i]  <= '0;
            div_q[i]    <= '0;
         end
         to_q       <= '0;
         run_q      <= '0;
         ito_q      <= '0;
         cont_q     <= '0;
         load_q     <= '0;
         irq_vec_q  <= '0;
         pulse_q    <= '0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         count_q    <= count_d;
         period_q   <= period_d;
         snap_q     <= snap_d;
         presc_q    <= presc_d;
         div_q      <= div_d;
         to_q       <= to_d;
         run_q      <= run_d;
         ito_q      <= ito_d;
         cont_q     <= cont_d;
         load_q     <= load_d;
         irq_vec_q  <= irq_vec_d;
         pulse_q    <= pulse_d;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata      = readdata_q;
   assign irq           = irq_q;
   assign irq_vec       = irq_vec_q;
   assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random bus traffic checked every cycle
// against a clock-by-clock register model of the timer.
module tb_multi_timer;
   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CNT_W  = 32;
   localparam bit [31:0]   MASK   = 32'hFFFF_FFFF >> (32 - CNT_W);
   localparam bit [31:0]   RST_P  = 32'h98967 & MASK;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [4:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;
   logic [NUM_CH-1:0] irq_vec;
   logic [NUM_CH-1:0] timeout_pulse;

   int checks = 0;
   int errors = 0;

   multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_PERIOD(32'h98967)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .irq_vec(irq_vec), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit [31:0] m_cnt [NUM_CH];
   bit [31:0] m_per [NUM_CH];
   bit [31:0] m_snap[NUM_CH];
   int        m_presc[NUM_CH];
   int        m_div [NUM_CH];
   bit        m_to  [NUM_CH];
   bit        m_run [NUM_CH];
   bit        m_ito [NUM_CH];
   bit        m_cont[NUM_CH];
   bit        m_load[NUM_CH];
   bit [31:0] m_rd;
   bit [NUM_CH-1:0] m_pulse, m_ivec;
   bit        m_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] adr(input int ch, input int r);
      return 5'((ch << 2) | r);
   endfunction

   function automatic bit [31:0] m_read(input bit [4:0] a);
      int c;
      c = int'(a[4:2]);
      if (c >= NUM_CH) return 32'd0;
      case (a[1:0])
         2'd0:    return {30'd0, m_run[c], m_to[c]};
         2'd1:    return (32'(m_presc[c]) << 8) | (32'(m_cont[c]) << 1) | 32'(m_ito[c]);
         2'd2:    return m_per[c];
         default: return m_snap[c];
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c] = RST_P;  m_per[c] = RST_P;  m_snap[c] = 0;
         m_presc[c] = 0;    m_div[c] = 0;      m_to[c] = 0;
         m_run[c] = 0;      m_ito[c] = 0;      m_cont[c] = 0;  m_load[c] = 0;
      end
      m_rd = 0; m_pulse = 0; m_ivec = 0; m_irq = 0;
   endtask

   // One clock of the timer as the register map describes it
   task automatic model_step(input bit cs, input bit wn, input bit [4:0] a, input bit [31:0] wd);
      bit wr;
      int wc, wreg;
      wr   = cs && !wn;
      wc   = int'(a[4:2]);
      wreg = int'(a[1:0]);
      m_rd = m_read(a);
      m_irq = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         bit hit, tick, evt, strt, stp, perw;
         bit [31:0] ncnt;
         hit  = wr && (wc == c);
         perw = hit && wreg == 2;
         strt = hit && wreg == 1 && wd[2];
         stp  = hit && wreg == 1 && wd[3];
         tick = m_run[c] && (m_div[c] == m_presc[c]);
         evt  = tick && (m_cnt[c] == 0);
         if (m_load[c] || evt) ncnt = m_per[c];
         else if (tick)        ncnt = (m_cnt[c] - 1) & MASK;
         else                  ncnt = m_cnt[c];
         m_div[c] = (!m_run[c] || tick || strt || perw) ? 0 : m_div[c] + 1;
         if (evt && !m_cont[c]) m_run[c] = 0;
         if (perw || stp)       m_run[c] = 0;
         if (strt)              m_run[c] = 1;
         if (hit && wreg == 0 && wd[0]) m_to[c] = 0;
         if (evt)                       m_to[c] = 1;
         if (hit && wreg == 3) m_snap[c] = m_cnt[c];
         m_cnt[c]  = ncnt;
         m_load[c] = perw;
         if (perw) m_per[c] = wd & MASK;
         if (hit && wreg == 1) begin
            m_ito[c] = wd[0]; m_cont[c] = wd[1]; m_presc[c] = int'(wd[15:8]);
         end
         m_pulse[c] = evt;
         m_ivec[c]  = m_to[c] && m_ito[c];
         if (m_ivec[c]) m_irq = 1;
      end
   endtask

   task automatic cyc(input bit cs, input bit wn, input bit [4:0] a, input bit [31:0] wd);
      chipselect = cs; write_n = wn; address = a; writedata = wd;
      @(posedge clk);
      model_step(cs, wn, a, wd);
      #1;
      check("readdata", readdata, m_rd);
      check("irq", 32'(irq), 32'(m_irq));
      check("irq_vec", 32'(irq_vec), 32'(m_ivec));
      check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
   endtask

   task automatic wr(input bit [4:0] a, input bit [31:0] d); cyc(1'b1, 1'b0, a, d); endtask
   task automatic rd(input bit [4:0] a);                     cyc(1'b1, 1'b1, a, 32'd0); endtask
   task automatic idle();                                    cyc(1'b0, 1'b1, 5'd0, 32'd0); endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int first, second, npulse;
      bit [4:0]  ra;
      bit [31:0] rdv;
      int        r;

      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      model_reset();
      @(posedge clk); #1;
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      release_reset();

      // Reset values
      rd(adr(0, 2)); check("rst_period", readdata, 32'h98967);
      rd(adr(0, 0)); check("rst_status", readdata, 32'd0);
      rd(adr(0, 1)); check("rst_control", readdata, 32'd0);

      // ch0 continuous, period 4: timeout every 5 clocks, W1C drops irq
      wr(adr(0, 2), 32'd4);
      wr(adr(0, 1), 32'h7);
      first = -1; second = -1;
      for (int i = 1; i <= 12; i++) begin
         idle();
         if (timeout_pulse[0]) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
         if (i == 5) check("ch0_irq_after_first", 32'(irq), 32'd1);
      end
      check("ch0_first_timeout", 32'(first), 32'd5);
      check("ch0_timeout_gap", 32'(second - first), 32'd5);
      wr(adr(0, 0), 32'd1);
      check("ch0_w1c_irq", 32'(irq), 32'd0);
      wr(adr(0, 1), 32'h8);

      // ch1 one-shot, period 2, prescale 3: one timeout 12 clocks after START
      wr(adr(1, 2), 32'd2);
      wr(adr(1, 1), 32'h305);
      first = -1; npulse = 0;
      for (int i = 1; i <= 20; i++) begin
         idle();
         if (timeout_pulse[1]) begin
            npulse++;
            if (first < 0) first = i;
         end
      end
      check("ch1_oneshot_time", 32'(first), 32'd12);
      check("ch1_oneshot_count", 32'(npulse), 32'd1);
      rd(adr(1, 0)); check("ch1_status_done", readdata, 32'd1);
      wr(adr(1, 3), 32'd0);
      rd(adr(1, 3)); check("ch1_reloaded", readdata, 32'd2);
      wr(adr(1, 0), 32'd1);

      // Timeout coincident with W1C keeps TO; START|STOP leaves RUN set
      wr(adr(0, 2), 32'd3);
      wr(adr(0, 1), 32'h7);
      repeat (3) idle();
      wr(adr(0, 0), 32'd1);
      check("w1c_vs_event_irq", 32'(irq), 32'd1);
      check("w1c_vs_event_pulse", 32'(timeout_pulse[0]), 32'd1);
      wr(adr(0, 1), 32'hC);
      rd(adr(0, 0)); check("start_stop_run", 32'(readdata[1:0]), 32'd3);

      // Snapshot of a running counter, then PERIOD write mid-run
      wr(adr(0, 2), 32'd200);
      wr(adr(0, 1), 32'h6);
      repeat (10) idle();
      wr(adr(0, 3), 32'd0);
      rd(adr(0, 3)); check("snap_running", readdata, 32'd190);
      wr(adr(0, 2), 32'd50);
      rd(adr(0, 0)); check("period_wr_run", 32'(readdata[1]), 32'd0);
      wr(adr(0, 3), 32'd0);
      rd(adr(0, 3)); check("period_wr_count", readdata, 32'd50);

      // Two channels running, then asynchronous reset mid-count
      wr(adr(0, 2), 32'd7);
      wr(adr(1, 2), 32'd3);
      wr(adr(0, 1), 32'h107);
      wr(adr(1, 1), 32'h7);
      repeat (9) idle();
      check("pre_reset_irq", 32'(irq), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_irq", 32'(irq), 32'd0);
      check("async_rst_irq_vec", 32'(irq_vec), 32'd0);
      check("async_rst_pulse", 32'(timeout_pulse), 32'd0);
      check("async_rst_readdata", readdata, 32'd0);
      chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      model_reset();
      release_reset();
      rd(adr(0, 2)); check("post_rst_period", readdata, 32'h98967);
      rd(adr(1, 0)); check("post_rst_status", readdata, 32'd0);

      // Out-of-range channel ignores writes and reads 0
      wr(adr(3, 2), 32'd5);
      rd(adr(3, 2)); check("ch3_read", readdata, 32'd0);

      // Random bus traffic against the model
      for (int n = 0; n < 3000; n++) begin
         ra = 5'($urandom_range(0, 15));
         r  = int'($urandom_range(0, 9));
         if (r < 6) begin
            cyc(1'($urandom_range(0, 1)), 1'b1, ra, $urandom);
         end else begin
            case (ra[1:0])
               2'd1:    rdv = 32'($urandom_range(0, 15)) | (32'($urandom_range(0, 3)) << 8);
               2'd2:    rdv = 32'($urandom_range(0, 9));
               default: rdv = 32'($urandom_range(0, 15));
            endcase
            wr(ra, rdv);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
